packet_queue_linker: RTL and testbench
======================================

PACKET_QUEUE_LINKER -- requirements
Module: packet_queue_linker

Interface
REQ-001 SHALL have parameter PORT_NUM, default 16, meaning number of destination ports.
REQ-002 SHALL have parameter PRIOR_NUM, default 8, meaning priority levels per port.
REQ-003 SHALL have parameter ADDR_W, default 16, meaning packet address width, {SRAM_IDX[4:0], page[10:0]}.
REQ-004 SHALL have port: clk  in  1  single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: time_stamp  out  5  free-running join-slot counter, broadcast to all SRAM interfaces.
REQ-007 SHALL have port: join_vld  in  1  packet join request, one-cycle pulse.
REQ-008 SHALL have ports: join_dest_port in 4, join_prior in 3, join_head in ADDR_W, join_tail in ADDR_W  describing the joining packet.
REQ-009 SHALL have port: deq_vld  in  1  pop the head packet of queue {deq_port in 4, deq_prior in 3}.
REQ-010 SHALL have port: deq_next_head  in  ADDR_W  head address of the next packet in that queue.
REQ-011 SHALL have ports: query_port in 4, query_prior in 3, query_head out ADDR_W, query_count out 16  queue lookup.
REQ-012 SHALL have port: port_nonempty  out  PORT_NUM  bit p set when any priority queue of port p holds a packet.
REQ-013 SHALL have ports: concatenate_enable out 1, concatenate_head out ADDR_W, concatenate_tail out ADDR_W  jump-table link command.
REQ-014 SHALL have ports: join_err out 1, deq_err out 1  one-cycle error pulses.

Function
REQ-015 SHALL maintain PORT_NUM*PRIOR_NUM queues, index q = {port, prior}, each holding head, tail and 16-bit count.
REQ-016 time_stamp SHALL increment by 1 every cycle, wrapping 31->0.
REQ-017 Join at cycle N to an empty queue SHALL set head<=join_head, tail<=join_tail, count<=1; no link command is issued.
REQ-018 Join at cycle N to a non-empty queue SHALL drive concatenate_enable=1, concatenate_head=old tail, concatenate_tail=join_head at cycle N+1 only.
REQ-019 In the same case (REQ-018), SHALL set tail<=join_tail and count+1.
REQ-020 Dequeue on a non-empty queue SHALL set head<=deq_next_head and count-1; on reaching count 0, head and tail become don't-care.
REQ-021 Dequeue on an empty queue SHALL change no state and pulse deq_err at N+1.
REQ-022 Join to a queue with count=65535 SHALL be dropped with join_err pulsed at N+1.
REQ-023 Simultaneous join and dequeue on different queues SHALL both apply independently in the same cycle.
REQ-024 Simultaneous join and dequeue on the same queue with count=1 SHALL load head/tail from the join, keep count=1, and issue no link.
REQ-025 Simultaneous join and dequeue on the same queue with count>1 SHALL set head<=deq_next_head, tail<=join_tail, keep count unchanged, and link as in REQ-018.
REQ-026 Simultaneous join and dequeue on the same empty queue SHALL apply the join (REQ-017) and pulse deq_err.
REQ-027 query_head and query_count SHALL be registered, reflecting state after all updates of the previous cycle (1-cycle latency).
REQ-028 port_nonempty SHALL be registered, updating the cycle after any count change.

Reset
REQ-029 While rst=1, every count SHALL be 0 and time_stamp SHALL be 0.
REQ-030 While rst=1, concatenate_enable, join_err, deq_err and port_nonempty SHALL be 0.
REQ-031 While rst=1, query_count SHALL be 0 and concatenate_head, concatenate_tail and query_head SHALL be 0.
REQ-032 rst asserted mid-operation SHALL discard all queues; join and dequeue requests in that cycle SHALL be ignored.

Structure
REQ-033 PORT_NUM, PRIOR_NUM, ADDR_W and the queue-index type SHALL live in the shared package hydra_pkg.
REQ-034 Per-queue head/tail/count storage with next-state merge SHALL be one sub-module, queue_table; the top module holds the time-slot counter, error and link logic.

Verification
REQ-035 Bench SHALL cover: reset, then join q(3,2) head=0x0810 tail=0x0815 -> no link; query(3,2) gives head 0x0810, count 1; port_nonempty=0x0008.
REQ-036 Bench SHALL cover: second join q(3,2) head=0x1020 tail=0x1022 -> next cycle link 0x0815->0x1020; count 2.
REQ-037 Bench SHALL cover: dequeue q(3,2) next_head=0x1020 together with join q(3,2) head=0x2000 -> link 0x1022->0x2000, head 0x1020, count 2.
REQ-038 Bench SHALL cover: dequeue empty q(5,0) -> deq_err pulse, no state change.
REQ-039 Bench SHALL cover: count=1 with simultaneous join and dequeue -> no link; head equals join_head; count 1.
REQ-040 Bench SHALL cover: time_stamp wraps 31->0; rst mid-stream clears all counts and port_nonempty.

Source files
------------

// File: rtl/hydra_pkg.sv
// rtl/hydra_pkg.sv - shared sizing constants and queue-index helpers
// Purpose: geometry of the packet queue linker (ports, priorities, address
//   width) and the mapping from {port, prior} to a flat queue index.
// Ports: none (package).
package hydra_pkg;

  localparam int PORT_NUM  = 16;
  localparam int PRIOR_NUM = 8;
  localparam int ADDR_W    = 16;
  localparam int CNT_W     = 16;
  localparam int QNUM      = PORT_NUM * PRIOR_NUM;
  localparam int QIDX_W    = $clog2(QNUM);

  typedef logic [QIDX_W-1:0] qidx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Queue q = {port, prior}; port is the major field.
  function automatic qidx_t q_index(input logic [3:0] port, input logic [2:0] prior);
    return {port, prior};
  endfunction

endpackage

// File: rtl/queue_table.sv
// rtl/queue_table.sv - per-queue head/tail/count storage with next-state merge
// Purpose: holds head, tail and count for every {port, prior} queue and merges
//   one join and one dequeue per cycle, including both hitting the same queue.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   join_en, join_port/prior      accepted join and its target queue
//   join_head, join_tail          packet being linked in
//   deq_en, deq_port/prior        accepted dequeue and its target queue
//   deq_next_head                 new head after the pop
//   query_port/prior              lookup selector
//   join_count, join_old_tail     current state of the join queue (combinational)
//   deq_count                     current count of the dequeue queue (combinational)
//   query_head, query_count       registered lookup result
//   port_nonempty                 registered per-port occupancy
module queue_table #(
  parameter int PORT_NUM  = 16,
  parameter int PRIOR_NUM = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                join_en,
  input  logic [3:0]          join_port,
  input  logic [2:0]          join_prior,
  input  logic [ADDR_W-1:0]   join_head,
  input  logic [ADDR_W-1:0]   join_tail,
  input  logic                deq_en,
  input  logic [3:0]          deq_port,
  input  logic [2:0]          deq_prior,
  input  logic [ADDR_W-1:0]   deq_next_head,
  input  logic [3:0]          query_port,
  input  logic [2:0]          query_prior,
  output logic [15:0]         join_count,
  output logic [ADDR_W-1:0]   join_old_tail,
  output logic [15:0]         deq_count,
  output logic [ADDR_W-1:0]   query_head,
  output logic [15:0]         query_count,
  output logic [PORT_NUM-1:0] port_nonempty
);
  import hydra_pkg::qidx_t;
  import hydra_pkg::q_index;

  localparam int QNUM = PORT_NUM * PRIOR_NUM;

  logic [ADDR_W-1:0]   head_q [QNUM];
  logic [ADDR_W-1:0]   head_d [QNUM];
  logic [ADDR_W-1:0]   tail_q [QNUM];
  logic [ADDR_W-1:0]   tail_d [QNUM];
  logic [15:0]         count_q [QNUM];
  logic [15:0]         count_d [QNUM];
  logic [ADDR_W-1:0]   query_head_q, query_head_d;
  logic [15:0]         query_count_q, query_count_d;
  logic [PORT_NUM-1:0] port_nonempty_q, port_nonempty_d;

  qidx_t jq, dq, qq;
  logic  same_q;

  assign jq     = q_index(join_port, join_prior);
  assign dq     = q_index(deq_port, deq_prior);
  assign qq     = q_index(query_port, query_prior);
  assign same_q = (jq == dq);

  assign join_count    = count_q[jq];
  assign join_old_tail = tail_q[jq];
  assign deq_count     = count_q[dq];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (deq_en) begin
      head_d[dq]  = deq_next_head;
      count_d[dq] = count_q[dq] - 16'd1;
    end

    if (join_en) begin
      if (deq_en && same_q) begin
        if (count_q[jq] == 16'd1) begin
          // The only packet leaves as the new one arrives: queue now holds just the joiner.
          head_d[jq]  = join_head;
          tail_d[jq]  = join_tail;
          count_d[jq] = 16'd1;
        end else begin
          // Head already advanced by the pop; one out, one in keeps the count.
          tail_d[jq]  = join_tail;
          count_d[jq] = count_q[jq];
        end
      end else if (count_q[jq] == 16'd0) begin
        head_d[jq]  = join_head;
        tail_d[jq]  = join_tail;
        count_d[jq] = 16'd1;
      end else begin
        tail_d[jq]  = join_tail;
        count_d[jq] = count_q[jq] + 16'd1;
      end
    end

    // Lookup and occupancy see this cycle's updates.
    query_head_d  = head_d[qq];
    query_count_d = count_d[qq];

    port_nonempty_d = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int r = 0; r < PRIOR_NUM; r++) begin
        if (count_d[q_index(4'(p), 3'(r))] != 16'd0) begin
          port_nonempty_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QNUM; i++) begin
        count_q[i] <= 16'd0;
      end
      query_head_q    <= '0;
      query_count_q   <= 16'd0;
      port_nonempty_q <= '0;
    end else begin
      count_q         <= count_d;
      query_head_q    <= query_head_d;
      query_count_q   <= query_count_d;
      port_nonempty_q <= port_nonempty_d;
    end
  end

  // Head/tail are meaningless while count is 0, so they need no reset.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign query_head    = query_head_q;
  assign query_count   = query_count_q;
  assign port_nonempty = port_nonempty_q;

endmodule

// File: rtl/packet_queue_linker.sv
// rtl/packet_queue_linker.sv - per-port/priority packet queue linker top
// Purpose: accepts packet joins and dequeues, keeps per-queue linked lists via
//   queue_table, issues jump-table link commands and error pulses, and runs
//   the free-running join time slot counter.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   time_stamp                             5-bit free-running slot counter
//   join_vld/dest_port/prior/head/tail     packet join request
//   deq_vld/port/prior/next_head           head pop request
//   query_port/prior, query_head/count     registered queue lookup
//   port_nonempty                          per-port occupancy
//   concatenate_enable/head/tail           link command (old tail -> new head)
//   join_err, deq_err                      full-queue join / empty-queue pop pulses
module packet_queue_linker #(
  parameter int PORT_NUM  = 16,
  parameter int PRIOR_NUM = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [4:0]          time_stamp,
  input  logic                join_vld,
  input  logic [3:0]          join_dest_port,
  input  logic [2:0]          join_prior,
  input  logic [ADDR_W-1:0]   join_head,
  input  logic [ADDR_W-1:0]   join_tail,
  input  logic                deq_vld,
  input  logic [3:0]          deq_port,
  input  logic [2:0]          deq_prior,
  input  logic [ADDR_W-1:0]   deq_next_head,
  input  logic [3:0]          query_port,
  input  logic [2:0]          query_prior,
  output logic [ADDR_W-1:0]   query_head,
  output logic [15:0]         query_count,
  output logic [PORT_NUM-1:0] port_nonempty,
  output logic                concatenate_enable,
  output logic [ADDR_W-1:0]   concatenate_head,
  output logic [ADDR_W-1:0]   concatenate_tail,
  output logic                join_err,
  output logic                deq_err
);
  import hydra_pkg::CNT_MAX;

  logic [15:0]       join_count, deq_count;
  logic [ADDR_W-1:0] join_old_tail;
  logic              same_q, join_en, deq_en, link;

  logic [4:0]        time_stamp_q, time_stamp_d;
  logic              concatenate_enable_q, concatenate_enable_d;
  logic [ADDR_W-1:0] concatenate_head_q, concatenate_head_d;
  logic [ADDR_W-1:0] concatenate_tail_q, concatenate_tail_d;
  logic              join_err_q, join_err_d;
  logic              deq_err_q, deq_err_d;

  queue_table #(
    .PORT_NUM (PORT_NUM),
    .PRIOR_NUM(PRIOR_NUM),
    .ADDR_W   (ADDR_W)
  ) u_queue_table (
    .clk          (clk),
    .rst          (rst),
    .join_en      (join_en),
    .join_port    (join_dest_port),
    .join_prior   (join_prior),
    .join_head    (join_head),
    .join_tail    (join_tail),
    .deq_en       (deq_en),
    .deq_port     (deq_port),
    .deq_prior    (deq_prior),
    .deq_next_head(deq_next_head),
    .query_port   (query_port),
    .query_prior  (query_prior),
    .join_count   (join_count),
    .join_old_tail(join_old_tail),
    .deq_count    (deq_count),
    .query_head   (query_head),
    .query_count  (query_count),
    .port_nonempty(port_nonempty)
  );

  always_comb begin
    same_q  = (join_dest_port == deq_port) && (join_prior == deq_prior);
    join_en = join_vld && (join_count != CNT_MAX);
    deq_en  = deq_vld && (deq_count != 16'd0);
    // No link when the queue was empty, or when its single packet is popped
    // in the same cycle (the joiner becomes the whole queue).
    link    = join_en && (join_count != 16'd0) &&
              !(deq_en && same_q && (join_count == 16'd1));

    time_stamp_d         = time_stamp_q + 5'd1;
    concatenate_enable_d = link;
    concatenate_head_d   = link ? join_old_tail : '0;
    concatenate_tail_d   = link ? join_head : '0;
    join_err_d           = join_vld && !join_en;
    deq_err_d            = deq_vld && !deq_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_stamp_q         <= 5'd0;
      concatenate_enable_q <= 1'b0;
      concatenate_head_q   <= '0;
      concatenate_tail_q   <= '0;
      join_err_q           <= 1'b0;
      deq_err_q            <= 1'b0;
    end else begin
      time_stamp_q         <= time_stamp_d;
      concatenate_enable_q <= concatenate_enable_d;
      concatenate_head_q   <= concatenate_head_d;
      concatenate_tail_q   <= concatenate_tail_d;
      join_err_q           <= join_err_d;
      deq_err_q            <= deq_err_d;
    end
  end

  assign time_stamp         = time_stamp_q;
  assign concatenate_enable = concatenate_enable_q;
  assign concatenate_head   = concatenate_head_q;
  assign concatenate_tail   = concatenate_tail_q;
  assign join_err           = join_err_q;
  assign deq_err            = deq_err_q;

endmodule

// File: tb/tb_packet_queue_linker.sv
// tb/tb_packet_queue_linker.sv - scoreboard bench for packet_queue_linker
module tb_packet_queue_linker;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  time_stamp;
  logic        join_vld;
  logic [3:0]  join_dest_port;
  logic [2:0]  join_prior;
  logic [15:0] join_head, join_tail;
  logic        deq_vld;
  logic [3:0]  deq_port;
  logic [2:0]  deq_prior;
  logic [15:0] deq_next_head;
  logic [3:0]  query_port;
  logic [2:0]  query_prior;
  logic [15:0] query_head, query_count;
  logic [15:0] port_nonempty;
  logic        concatenate_enable;
  logic [15:0] concatenate_head, concatenate_tail;
  logic        join_err, deq_err;

  packet_queue_linker #(.PORT_NUM(16), .PRIOR_NUM(8), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .time_stamp        (time_stamp),
    .join_vld          (join_vld),
    .join_dest_port    (join_dest_port),
    .join_prior        (join_prior),
    .join_head         (join_head),
    .join_tail         (join_tail),
    .deq_vld           (deq_vld),
    .deq_port          (deq_port),
    .deq_prior         (deq_prior),
    .deq_next_head     (deq_next_head),
    .query_port        (query_port),
    .query_prior       (query_prior),
    .query_head        (query_head),
    .query_count       (query_count),
    .port_nonempty     (port_nonempty),
    .concatenate_enable(concatenate_enable),
    .concatenate_head  (concatenate_head),
    .concatenate_tail  (concatenate_tail),
    .join_err          (join_err),
    .deq_err           (deq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] h;
    logic [15:0] t;
  } link_t;

  link_t link_exp[$];
  bit    deq_err_exp[$];
  int    checks   = 0;
  int    failures = 0;

  logic [4:0] ts_exp;
  always @(posedge clk) ts_exp <= rst ? 5'd0 : ts_exp + 5'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every pulse the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (concatenate_enable === 1'b1) begin
      checks++;
      if (link_exp.size() == 0) begin
        failures++;
        $display("FAIL link_unexpected actual=0x%0h->0x%0h expected=none", concatenate_head, concatenate_tail);
      end else begin
        link_t e;
        e = link_exp.pop_front();
        if (concatenate_head !== e.h || concatenate_tail !== e.t) begin
          failures++;
          $display("FAIL link actual=0x%0h->0x%0h expected=0x%0h->0x%0h", concatenate_head, concatenate_tail, e.h, e.t);
        end
      end
    end
    if (deq_err === 1'b1) begin
      checks++;
      if (deq_err_exp.size() == 0) begin
        failures++;
        $display("FAIL deq_err_unexpected actual=1 expected=0");
      end else begin
        void'(deq_err_exp.pop_front());
      end
    end
    if (join_err === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL join_err_unexpected actual=1 expected=0");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic jv, input logic [3:0] jp, input logic [2:0] jpr,
                    input logic [15:0] jh, input logic [15:0] jt,
                    input logic dv, input logic [3:0] dp, input logic [2:0] dpr,
                    input logic [15:0] dnh);
    join_vld = jv; join_dest_port = jp; join_prior = jpr; join_head = jh; join_tail = jt;
    deq_vld = dv; deq_port = dp; deq_prior = dpr; deq_next_head = dnh;
    step();
    join_vld = 1'b0;
    deq_vld  = 1'b0;
  endtask

  task automatic query_chk(input string nm, input logic [3:0] p, input logic [2:0] pr,
                           input logic chk_head, input logic [15:0] exp_head,
                           input logic [15:0] exp_count, input logic [15:0] exp_pne);
    query_port  = p;
    query_prior = pr;
    step();
    @(negedge clk);
    if (chk_head) chk({nm, "_head"}, 32'(query_head), 32'(exp_head));
    chk({nm, "_count"}, 32'(query_count), 32'(exp_count));
    chk({nm, "_pne"}, 32'(port_nonempty), 32'(exp_pne));
  endtask

  initial begin
    logic [4:0] prev_ts;
    logic       wrap_seen;

    rst = 1'b1;
    join_vld = 1'b0; join_dest_port = '0; join_prior = '0; join_head = '0; join_tail = '0;
    deq_vld = 1'b0; deq_port = '0; deq_prior = '0; deq_next_head = '0;
    query_port = 4'd3; query_prior = 3'd2;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_time_stamp", 32'(time_stamp), 32'd0);
    chk("rst_concat_en", 32'(concatenate_enable), 32'd0);
    chk("rst_concat_head", 32'(concatenate_head), 32'd0);
    chk("rst_concat_tail", 32'(concatenate_tail), 32'd0);
    chk("rst_join_err", 32'(join_err), 32'd0);
    chk("rst_deq_err", 32'(deq_err), 32'd0);
    chk("rst_pne", 32'(port_nonempty), 32'd0);
    chk("rst_query_count", 32'(query_count), 32'd0);
    chk("rst_query_head", 32'(query_head), 32'd0);
    step();
    rst = 1'b0;

    // First join to empty q(3,2): no link
    op(1'b1, 4'd3, 3'd2, 16'h0810, 16'h0815, 1'b0, 4'd0, 3'd0, 16'h0);
    query_chk("j1", 4'd3, 3'd2, 1'b1, 16'h0810, 16'd1, 16'h0008);

    // Second join: link old tail -> new head
    link_exp.push_back('{h: 16'h0815, t: 16'h1020});
    op(1'b1, 4'd3, 3'd2, 16'h1020, 16'h1022, 1'b0, 4'd0, 3'd0, 16'h0);
    query_chk("j2", 4'd3, 3'd2, 1'b1, 16'h0810, 16'd2, 16'h0008);

    // Join + dequeue same queue, count 2
    link_exp.push_back('{h: 16'h1022, t: 16'h2000});
    op(1'b1, 4'd3, 3'd2, 16'h2000, 16'h2005, 1'b1, 4'd3, 3'd2, 16'h1020);
    query_chk("jd2", 4'd3, 3'd2, 1'b1, 16'h1020, 16'd2, 16'h0008);

    // Dequeue empty q(5,0)
    deq_err_exp.push_back(1'b1);
    op(1'b0, 4'd0, 3'd0, 16'h0, 16'h0, 1'b1, 4'd5, 3'd0, 16'h7777);
    query_chk("deq_empty50", 4'd5, 3'd0, 1'b0, 16'h0, 16'd0, 16'h0008);
    query_chk("deq_empty32", 4'd3, 3'd2, 1'b1, 16'h1020, 16'd2, 16'h0008);

    // Pop to count 1, then join + dequeue at count 1: no link
    op(1'b0, 4'd0, 3'd0, 16'h0, 16'h0, 1'b1, 4'd3, 3'd2, 16'h2000);
    query_chk("pop1", 4'd3, 3'd2, 1'b1, 16'h2000, 16'd1, 16'h0008);
    op(1'b1, 4'd3, 3'd2, 16'h3000, 16'h3003, 1'b1, 4'd3, 3'd2, 16'h5555);
    query_chk("jd1", 4'd3, 3'd2, 1'b1, 16'h3000, 16'd1, 16'h0008);
    // Tail must now be the joiner's tail
    link_exp.push_back('{h: 16'h3003, t: 16'h4000});
    op(1'b1, 4'd3, 3'd2, 16'h4000, 16'h4004, 1'b0, 4'd0, 3'd0, 16'h0);
    query_chk("j3", 4'd3, 3'd2, 1'b1, 16'h3000, 16'd2, 16'h0008);

    // Join + dequeue on same empty queue: join applies, deq_err
    deq_err_exp.push_back(1'b1);
    op(1'b1, 4'd9, 3'd4, 16'h0900, 16'h0901, 1'b1, 4'd9, 3'd4, 16'h1234);
    query_chk("jd0", 4'd9, 3'd4, 1'b1, 16'h0900, 16'd1, 16'h0208);

    // Join and dequeue on different queues
    op(1'b1, 4'd7, 3'd1, 16'h0700, 16'h0701, 1'b1, 4'd3, 3'd2, 16'h4000);
    query_chk("diff71", 4'd7, 3'd1, 1'b1, 16'h0700, 16'd1, 16'h0288);
    query_chk("diff32", 4'd3, 3'd2, 1'b1, 16'h4000, 16'd1, 16'h0288);

    // time_stamp wraps 31 -> 0
    step();
    wrap_seen = 1'b0;
    prev_ts   = 5'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("time_stamp", 32'(time_stamp), 32'(ts_exp));
      if (i > 0 && prev_ts == 5'd31 && time_stamp == 5'd0) wrap_seen = 1'b1;
      prev_ts = time_stamp;
    end
    chk("ts_wrap", 32'(wrap_seen), 32'd1);
    step();

    // Mid-stream reset with requests in the same cycle
    rst = 1'b1;
    op(1'b1, 4'd1, 3'd0, 16'h1111, 16'h1112, 1'b1, 4'd3, 3'd2, 16'h2222);
    rst = 1'b0;
    query_chk("mrst10", 4'd1, 3'd0, 1'b0, 16'h0, 16'd0, 16'h0000);
    query_chk("mrst32", 4'd3, 3'd2, 1'b0, 16'h0, 16'd0, 16'h0000);
    op(1'b1, 4'd3, 3'd2, 16'h6000, 16'h6001, 1'b0, 4'd0, 3'd0, 16'h0);
    query_chk("post_rst", 4'd3, 3'd2, 1'b1, 16'h6000, 16'd1, 16'h0008);

    repeat (3) step();
    chk("link_pending", 32'(link_exp.size()), 32'd0);
    chk("deq_err_pending", 32'(deq_err_exp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
